// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 5-stage RV32 core.
// It tracks the in-flight writers in EX/MEM/WB and stalls on every RAW
// hazard, because the core has no forwarding. It also runs the
// data-memory handshake, the branch/jump flush, and a sticky
// memory-timeout error.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_reg1_read,
  input  logic             id_reg2_read,
  input  logic [4:0]       id_reg1_addr,
  input  logic [4:0]       id_reg2_addr,
  input  logic [4:0]       id_wd,
  input  logic             id_mem,
  input  logic             ex_br_taken,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_en,
  output logic             id_en,
  output logic             flush,
  output logic             mem_req,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_MEM_WAIT, S_ERR} state_t;

  state_t           state, state_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;

  logic       ex_v, mem_v, wb_v;
  logic [4:0] ex_wd, mem_wd, wb_wd;
  logic       ex_mem, mem_mem, wb_mem;

  logic advance, take_id, hazard;

  function automatic logic slot_hit(input logic v, input logic [4:0] wd,
                                    input logic r1, input logic [4:0] a1,
                                    input logic r2, input logic [4:0] a2);
    return v && (wd != 5'd0) && ((r1 && (wd == a1)) || (r2 && (wd == a2)));
  endfunction

  // RAW check of the decoded instruction against every in-flight writer.
  always_comb begin
    hazard = id_valid && (
      slot_hit(ex_v,  ex_wd,  id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr) ||
      slot_hit(mem_v, mem_wd, id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr) ||
      slot_hit(wb_v,  wb_wd,  id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr));
  end

  // Next-state and enable generation.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    advance   = 1'b0;
    take_id   = 1'b0;
    pc_en     = 1'b0;
    if_en     = 1'b0;
    id_en     = 1'b0;
    flush     = 1'b0;
    mem_req   = 1'b0;
    err       = 1'b0;
    case (state)
      S_RUN: begin
        advance = 1'b1;
        if (ex_br_taken && ex_v) begin
          flush     = 1'b1;
          pc_en     = 1'b1;
          if_en     = 1'b1;
          state_nxt = S_FLUSH;
        end else if (!hazard) begin
          pc_en   = 1'b1;
          if_en   = 1'b1;
          id_en   = id_valid;
          take_id = id_valid;
        end
      end
      S_FLUSH: begin
        advance   = 1'b1;
        pc_en     = 1'b1;
        if_en     = 1'b1;
        state_nxt = S_RUN;
      end
      S_MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          advance   = 1'b1;
          tmo_nxt   = '0;
          state_nxt = S_RUN;
        end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
          tmo_nxt   = '0;
          state_nxt = S_ERR;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      default: begin
        err = 1'b1;
      end
    endcase
    // A memory op moving from EX into MEM always parks the pipe.
    if (advance && ex_v && ex_mem) begin
      state_nxt = S_MEM_WAIT;
    end
    if (rst) begin
      pc_en   = 1'b0;
      if_en   = 1'b0;
      id_en   = 1'b0;
      flush   = 1'b0;
      mem_req = 1'b0;
      err     = 1'b0;
    end
  end

  // FSM state and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  // Shadow slots EX -> MEM -> WB; a bubble enters EX unless ID is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v    <= 1'b0;
      ex_wd   <= 5'd0;
      ex_mem  <= 1'b0;
      mem_v   <= 1'b0;
      mem_wd  <= 5'd0;
      mem_mem <= 1'b0;
      wb_v    <= 1'b0;
      wb_wd   <= 5'd0;
      wb_mem  <= 1'b0;
    end else if (advance) begin
      wb_v    <= mem_v;
      wb_wd   <= mem_wd;
      wb_mem  <= mem_mem;
      mem_v   <= ex_v;
      mem_wd  <= ex_wd;
      mem_mem <= ex_mem;
      ex_v    <= take_id;
      ex_wd   <= take_id ? id_wd : 5'd0;
      ex_mem  <= take_id & id_mem;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. It runs directed scenarios followed by a
// random stream. The reference model tracks in-flight instructions by age.
module tb_pipe_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 5;
  localparam int SMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_reg1_read, id_reg2_read, id_mem, ex_br_taken, mem_ack;
  logic [4:0]    id_reg1_addr, id_reg2_addr, id_wd;
  logic          pc_en, if_en, id_en, flush, mem_req, err;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_wd(id_wd), .id_mem(id_mem), .ex_br_taken(ex_br_taken), .mem_ack(mem_ack),
    .pc_en(pc_en), .if_en(if_en), .id_en(id_en), .flush(flush),
    .mem_req(mem_req), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each in-flight instruction carries its age
  // (0 = EX, 1 = MEM, 2 = WB).
  typedef struct {int age; logic [4:0] wd; bit mm;} ent_t;
  ent_t q[$];
  bit   in_flush = 0, waiting = 0, failed = 0;
  int   wcnt = 0, m_stall = 0;
  bit   e_pc, e_if, e_id, e_flush, e_req, e_err;

  function automatic bit m_hazard();
    if (!id_valid) return 0;
    foreach (q[i])
      if (q[i].wd != 0 && ((id_reg1_read && q[i].wd == id_reg1_addr) ||
                           (id_reg2_read && q[i].wd == id_reg2_addr))) return 1;
    return 0;
  endfunction

  function automatic bit m_ex_valid();
    foreach (q[i]) if (q[i].age == 0) return 1;
    return 0;
  endfunction

  task automatic model_outputs();
    {e_pc, e_if, e_id, e_flush, e_req, e_err} = '0;
    if (rst) return;
    if (failed) e_err = 1;
    else if (waiting) e_req = 1;
    else if (in_flush) begin e_pc = 1; e_if = 1; end
    else if (ex_br_taken && m_ex_valid()) begin e_flush = 1; e_pc = 1; e_if = 1; end
    else if (!m_hazard()) begin e_pc = 1; e_if = 1; e_id = id_valid; end
  endtask

  task automatic m_advance(input bit take, output bit entered);
    ent_t nq[$];
    entered = 0;
    foreach (q[i]) begin
      ent_t e = q[i];
      e.age++;
      if (e.age <= 2) begin
        nq.push_back(e);
        if (e.age == 1 && e.mm) entered = 1;
      end
    end
    if (take) nq.push_back('{0, id_wd, id_mem});
    q = nq;
  endtask

  task automatic model_update();
    bit ent;
    if (rst) begin
      q.delete(); in_flush = 0; waiting = 0; failed = 0; wcnt = 0; m_stall = 0;
      return;
    end
    if (!e_pc && m_stall < SMAX) m_stall++;
    if (failed) return;
    if (waiting) begin
      wcnt++;
      if (mem_ack) begin
        m_advance(0, ent);
        wcnt = 0;
        waiting = ent;
      end else if (wcnt >= TO) begin
        failed = 1; waiting = 0;
      end
    end else begin
      m_advance(e_id, ent);
      in_flush = e_flush;
      if (ent) begin waiting = 1; in_flush = 0; end
    end
  endtask

  // One clock: inputs are already driven (we are at a negedge).
  task automatic cycle();
    #1;
    model_outputs();
    check("pc_en",     pc_en,     e_pc);
    check("if_en",     if_en,     e_if);
    check("id_en",     id_en,     e_id);
    check("flush",     flush,     e_flush);
    check("mem_req",   mem_req,   e_req);
    check("err",       err,       e_err);
    check("stall_cnt", stall_cnt, m_stall);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_reg1_read = 0; id_reg2_read = 0;
    id_reg1_addr = 0; id_reg2_addr = 0; id_wd = 0; id_mem = 0;
    ex_br_taken = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  task automatic instr(input bit mm, input logic [4:0] wd, input bit r1, input logic [4:0] a1);
    idle(); id_valid = 1; id_mem = mm; id_wd = wd; id_reg1_read = r1; id_reg1_addr = a1;
  endtask

  initial begin
    idle(); rst = 1;
    @(negedge clk);
    cycle(); cycle();

    // independent stream
    do_reset();
    for (int i = 0; i < 5; i++) begin instr(0, 5'(i + 1), 1, 5'(i + 10)); cycle(); end
    check("indep_stall_cnt", stall_cnt, 0);

    // RAW on x5, then the same against x0
    do_reset();
    instr(0, 5, 0, 0); cycle();
    for (int i = 0; i < 4; i++) begin instr(0, 6, 1, 5); cycle(); end
    check("raw_stall_cnt", stall_cnt, 3);
    instr(0, 0, 0, 0); cycle();
    instr(0, 7, 1, 0); cycle();
    check("x0_no_stall", stall_cnt, 3);

    // load with ack on the 4th wait cycle; the early ack is ignored
    do_reset();
    instr(1, 8, 0, 0); cycle();
    for (int i = 0; i < 6; i++) begin idle(); mem_ack = (i == 0 || i == 4); cycle(); end
    check("load_stall_cnt", stall_cnt, 4);

    // branch flush, taken again during FLUSH
    do_reset();
    instr(0, 3, 0, 0); cycle();
    instr(0, 4, 0, 0); ex_br_taken = 1; cycle();
    instr(0, 9, 0, 0); ex_br_taken = 1; cycle();
    instr(0, 9, 0, 0); cycle();

    // timeout to ERR, then recovery
    do_reset();
    instr(1, 0, 0, 0); cycle();
    for (int i = 0; i < 25; i++) begin instr(0, 2, 0, 0); cycle(); end
    check("err_sticky", err, 1);
    do_reset();
    instr(0, 2, 0, 0); cycle();

    // reset on the 2nd wait cycle
    do_reset();
    instr(1, 8, 0, 0); cycle();
    idle(); cycle(); cycle();
    rst = 1; cycle();
    for (int i = 0; i < 3; i++) begin instr(0, 5'(i + 1), 0, 0); cycle(); end
    check("midwait_stall_cnt", stall_cnt, 0);

    // random stream
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      id_valid     = ($urandom_range(0, 9) < 7);
      id_reg1_read = $urandom_range(0, 1);
      id_reg2_read = $urandom_range(0, 1);
      id_reg1_addr = 5'($urandom_range(0, 7));
      id_reg2_addr = 5'($urandom_range(0, 7));
      id_wd        = 5'($urandom_range(0, 7));
      id_mem       = ($urandom_range(0, 99) < 15);
      ex_br_taken  = ($urandom_range(0, 9) == 0);
      mem_ack      = ($urandom_range(0, 9) < 4);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
